// File: rtl/protocol_rx_parser_pkg.sv
// Shared protocol definitions: command codes, request argument layouts,
// parser FSM states and request-length helpers.
package protocol_rx_parser_pkg;

  localparam logic [7:0] PROTOCOL_VERSION = 8'd2;

  typedef enum logic [7:0] {
    IDENTIFY   = 8'h00,
    SET_SIGNAL = 8'h01,
    AUTO_READ  = 8'h02,
    GET_RESULT = 8'h03,
    ABORT      = 8'h04
  } Command;

  // Argument layouts, first received byte in the MSBs
  typedef struct packed {
    logic [31:0] signal;
  } SetSignalRequestArgs;

  typedef struct packed {
    logic [15:0] period;
    logic [15:0] count;
    logic [47:0] cfg;
  } AutoReadRequestArgs;

  typedef enum logic [2:0] {
    S_IDLE, S_MAGIC, S_CMD, S_CHAN, S_ARGS, S_HOLD
  } rx_state_e;

  function automatic logic is_known_cmd(input logic [7:0] c);
    case (c)
      IDENTIFY, SET_SIGNAL, AUTO_READ, GET_RESULT, ABORT: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] get_request_arg_len(input Command c);
    case (c)
      SET_SIGNAL: return 4'd4;
      AUTO_READ:  return 4'd10;
      default:    return 4'd0;
    endcase
  endfunction

  // Magic + command + optional channel + args; CRC is added by the caller
  function automatic logic [4:0] get_request_len(input Command c, input logic has_chan);
    return 5'd5 + {4'b0, has_chan} + {1'b0, get_request_arg_len(c)};
  endfunction

endpackage

// File: rtl/protocol_rx_parser_magic.sv
// Byte-indexed magic compare with a sticky mismatch bit; mismatch also
// reflects the byte presented this cycle so a frame ending on it is covered.
module protocol_magic_checker #(
  parameter logic [31:0] MAGIC = 32'hF100BA00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       byte_vld,
  input  logic [1:0] byte_idx,
  input  logic [7:0] byte_data,
  output logic       mismatch
);

  logic       mis_q;
  logic [7:0] exp_byte;
  logic       bad_now;

  // Select the expected magic byte, MSB first
  always_comb begin
    case (byte_idx)
      2'd0:    exp_byte = MAGIC[31:24];
      2'd1:    exp_byte = MAGIC[23:16];
      2'd2:    exp_byte = MAGIC[15:8];
      default: exp_byte = MAGIC[7:0];
    endcase
    bad_now  = byte_vld && (byte_data != exp_byte);
    mismatch = mis_q | bad_now;
  end

  // Sticky mismatch, cleared at frame end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       mis_q <= 1'b0;
    else if (clr)     mis_q <= 1'b0;
    else if (bad_now) mis_q <= 1'b1;
  end

endmodule

// File: rtl/protocol_rx_parser.sv
// Request parser: collects one frame, decodes header/args and holds the
// decoded message until the app accepts it. Input is never back-pressured.
module protocol_rx_parser
  import protocol_rx_parser_pkg::*;
#(
  parameter logic [31:0] MAGIC          = 32'hF100BA00,
  parameter int          NUM_CHANNELS   = 4,
  parameter int          ARGS_MAX_BYTES = 10,
  parameter int          CRC_BYTES      = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  input  logic                          in_eom,
  input  logic                          in_crc_err,
  output logic                          msg_valid,
  input  logic                          msg_ready,
  output logic [7:0]                    msg_cmd,
  output logic [((NUM_CHANNELS>1)?$clog2(NUM_CHANNELS):1)-1:0] msg_chan,
  output logic [ARGS_MAX_BYTES*8-1:0]   msg_args,
  output logic [4:0]                    msg_len,
  output logic                          msg_foreign,
  output logic                          msg_error,
  output logic                          msg_overrun
);

  localparam int   CW       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam logic HAS_CHAN = (NUM_CHANNELS > 1);
  localparam int   HDR      = 5 + (HAS_CHAN ? 1 : 0);

  rx_state_e state, state_nx;
  logic [4:0] cnt;
  logic [7:0] cmd_q, chan_q, cmd_nx, chan_nx;
  logic [ARGS_MAX_BYTES-1:0][7:0] args_q, args_nx, args_commit;
  logic [4:0] len_nx;
  logic take, commit, hs, drop, mag_bad, foreign_nx, error_nx, ovr_q;
  int   keep;

  assign take   = (state != S_HOLD) && in_valid;
  assign commit = take && in_eom && !in_crc_err;
  assign hs     = msg_valid && msg_ready;
  assign drop   = (state == S_HOLD) && in_valid && in_eom;

  protocol_magic_checker #(.MAGIC(MAGIC)) u_magic (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (take && in_eom),
    .byte_vld  (take && (cnt < 5'd4)),
    .byte_idx  (cnt[1:0]),
    .byte_data (in_data),
    .mismatch  (mag_bad)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  // Next state; any end of frame while collecting overrides the field walk
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = S_MAGIC;
      S_MAGIC: if (in_valid && cnt == 5'd3) state_nx = S_CMD;
      S_CMD:   if (in_valid) state_nx = HAS_CHAN ? S_CHAN : S_ARGS;
      S_CHAN:  if (in_valid) state_nx = S_ARGS;
      S_ARGS:  state_nx = S_ARGS;
      S_HOLD:  if (msg_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
    if (take && in_eom) state_nx = in_crc_err ? S_IDLE : S_HOLD;
  end

  // Field capture including the current byte, plus decode of the result
  always_comb begin
    cmd_nx  = cmd_q;
    chan_nx = chan_q;
    args_nx = args_q;
    if (take && cnt == 5'd4) cmd_nx = in_data;
    if (take && HAS_CHAN && cnt == 5'd5) chan_nx = in_data;
    for (int i = 0; i < ARGS_MAX_BYTES; i++)
      if (take && int'(cnt) == HDR + i) args_nx[ARGS_MAX_BYTES-1-i] = in_data;
    len_nx = (cnt == 5'd31) ? 5'd31 : cnt + 5'd1;
    // Trailing CRC bytes landed in the shadow buffer; mask them off here
    keep = int'(len_nx) - CRC_BYTES - HDR;
    for (int i = 0; i < ARGS_MAX_BYTES; i++)
      args_commit[ARGS_MAX_BYTES-1-i] = (i < keep) ? args_nx[ARGS_MAX_BYTES-1-i] : 8'h00;
    foreign_nx = mag_bad || (len_nx < 5'd4);
    error_nx   = !foreign_nx &&
                 (!is_known_cmd(cmd_nx) ||
                  int'(len_nx) != int'(get_request_len(Command'(cmd_nx), HAS_CHAN)) + CRC_BYTES ||
                  (HAS_CHAN && int'(chan_nx) >= NUM_CHANNELS));
  end

  // Shadow frame state, cleared whenever a frame ends
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0; cmd_q <= '0; chan_q <= '0; args_q <= '0;
    end else if (take) begin
      if (in_eom) begin
        cnt <= '0; cmd_q <= '0; chan_q <= '0; args_q <= '0;
      end else begin
        cnt <= len_nx; cmd_q <= cmd_nx; chan_q <= chan_nx; args_q <= args_nx;
      end
    end
  end

  // Presented message, held until handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_valid <= 1'b0; msg_cmd <= '0; msg_chan <= '0; msg_args <= '0;
      msg_len <= '0; msg_foreign <= 1'b0; msg_error <= 1'b0; msg_overrun <= 1'b0;
    end else if (commit) begin
      msg_valid   <= 1'b1;
      msg_cmd     <= cmd_nx;
      msg_chan    <= chan_nx[CW-1:0];
      msg_args    <= args_commit;
      msg_len     <= len_nx;
      msg_foreign <= foreign_nx;
      msg_error   <= error_nx;
      msg_overrun <= ovr_q;
    end else if (hs) begin
      msg_valid <= 1'b0;
    end
  end

  // Sticky overrun: cleared once a message carrying it is taken; a drop in
  // the same cycle as that handshake belongs to the following message
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovr_q <= 1'b0;
    else        ovr_q <= ((hs && msg_overrun) ? 1'b0 : ovr_q) | drop;
  end

endmodule

// File: tb/tb_protocol_rx_parser.sv
// Directed bench: 4-channel parser plus a single-channel (v1 framing) build.
module tb_protocol_rx_parser;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic v0 = 0, e0 = 0, c0 = 0, r0 = 0;
  logic [7:0] d0 = '0;
  logic mv0, for0, err0, ovr0;
  logic [7:0] cmd0;
  logic [1:0] chan0;
  logic [79:0] args0;
  logic [4:0] len0;

  logic v1 = 0, e1 = 0, c1 = 0, r1 = 0;
  logic [7:0] d1 = '0;
  logic mv1, for1, err1, ovr1;
  logic [7:0] cmd1;
  logic [0:0] chan1;
  logic [79:0] args1;
  logic [4:0] len1;

  protocol_rx_parser #(.NUM_CHANNELS(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(v0), .in_data(d0), .in_eom(e0),
    .in_crc_err(c0), .msg_valid(mv0), .msg_ready(r0), .msg_cmd(cmd0),
    .msg_chan(chan0), .msg_args(args0), .msg_len(len0), .msg_foreign(for0),
    .msg_error(err0), .msg_overrun(ovr0));

  protocol_rx_parser #(.NUM_CHANNELS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(v1), .in_data(d1), .in_eom(e1),
    .in_crc_err(c1), .msg_valid(mv1), .msg_ready(r1), .msg_cmd(cmd1),
    .msg_chan(chan1), .msg_args(args1), .msg_len(len1), .msg_foreign(for1),
    .msg_error(err1), .msg_overrun(ovr1));

  int n_chk = 0, n_err = 0;
  logic [7:0] fq[$];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive fq as one frame; optionally check msg_valid is still low while eom is offered
  task automatic send_fq(input bit sel, input bit crc_err, input bit eom, input bit lat);
    for (int i = 0; i < fq.size(); i++) begin
      @(negedge clk);
      if (sel) begin
        v1 = 1; d1 = fq[i]; e1 = eom && (i == fq.size()-1); c1 = crc_err && e1;
      end else begin
        v0 = 1; d0 = fq[i]; e0 = eom && (i == fq.size()-1); c0 = crc_err && e0;
      end
      if (lat && i == fq.size()-1) chk("latency_pre", mv0, 1'b0);
    end
    @(negedge clk);
    v0 = 0; e0 = 0; c0 = 0; v1 = 0; e1 = 0; c1 = 0;
  endtask

  task automatic handshake(input bit sel, input string tag);
    @(negedge clk);
    if (sel) r1 = 1; else r0 = 1;
    @(negedge clk);
    r0 = 0; r1 = 0;
    chk(tag, sel ? mv1 : mv0, 1'b0);
  endtask

  initial begin
    #12;
    chk("rst_valid", mv0, 1'b0);
    chk("rst_fields", {cmd0, chan0, args0, len0, for0, err0, ovr0}, '0);
    @(negedge clk) rst_n = 1;

    // SET_SIGNAL on channel 2
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h01, 8'h02, 8'h12, 8'h34, 8'hFF, 8'hA5, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 1);
    chk("set_valid", mv0, 1'b1);
    chk("set_cmd", cmd0, 8'h01);
    chk("set_chan", chan0, 2'd2);
    chk("set_args", args0, 80'h1234FFA5_000000000000);
    chk("set_len", len0, 5'd12);
    chk("set_flags", {err0, for0, ovr0}, 3'b000);
    handshake(0, "set_drop");

    // Foreign magic
    fq = '{8'hF1, 8'h00, 8'hBB, 8'h00, 8'h00, 8'h00, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("foreign_flags", {mv0, for0, err0}, 3'b110);
    handshake(0, "foreign_drop");

    // Frame ending inside the magic
    fq = '{8'hF1, 8'h00, 8'hBA};
    send_fq(0, 0, 1, 0);
    chk("short_flags", {mv0, for0, err0, len0}, {3'b110, 5'd3});
    handshake(0, "short_drop");

    // AUTO_READ with only 4 args
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    send_fq(0, 0, 1, 0);
    chk("autord_err", {err0, for0, len0}, {2'b10, 5'd12});
    chk("autord_args", args0, 80'hAABBCCDD_000000000000);
    handshake(0, "autord_drop");

    // Unknown command
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h07, 8'h00, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("badcmd_err", {err0, for0, cmd0}, {2'b10, 8'h07});
    handshake(0, "badcmd_drop");

    // Channel out of range
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h00, 8'h05, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("badchan_err", {err0, for0}, 2'b10);
    handshake(0, "badchan_drop");

    // Back-pressure: A held, B dropped, C reports overrun
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h00, 8'h01, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h01, 8'h02, 8'h12, 8'h34, 8'hFF, 8'hA5, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    repeat (27) @(negedge clk);
    chk("hold_valid", mv0, 1'b1);
    chk("hold_fields", {cmd0, chan0, len0, err0, ovr0}, {8'h00, 2'd1, 5'd8, 2'b00});
    handshake(0, "hold_drop");
    repeat (2) @(negedge clk);
    chk("b_discarded", mv0, 1'b0);
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h03, 8'h03, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("c_fields", {mv0, cmd0, chan0, err0, ovr0}, {1'b1, 8'h03, 2'd3, 2'b01});
    handshake(0, "c_drop");
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h04, 8'h00, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("d_ovr_clear", {mv0, cmd0, err0, ovr0}, {1'b1, 8'h04, 2'b00});
    handshake(0, "d_drop");

    // Async reset after 6 bytes of a frame
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h02, 8'h01};
    send_fq(0, 0, 0, 0);
    #2 rst_n = 0;
    #1 chk("arst_fields", {mv0, cmd0, chan0, len0}, '0);
    @(negedge clk) rst_n = 1;
    repeat (2) @(negedge clk);
    chk("arst_no_msg", mv0, 1'b0);
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h00, 8'h03, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("ident_after_rst", {mv0, cmd0, chan0, len0, err0, for0},
        {1'b1, 8'h00, 2'd3, 5'd8, 2'b00});
    handshake(0, "ident_drop");

    // CRC error discards the frame silently
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h00, 8'h01, 8'hCC, 8'hDD};
    send_fq(0, 1, 1, 0);
    chk("crc_no_msg0", mv0, 1'b0);
    repeat (3) @(negedge clk);
    chk("crc_no_msg1", mv0, 1'b0);
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h03, 8'h02, 8'hCC, 8'hDD};
    send_fq(0, 0, 1, 0);
    chk("after_crc", {mv0, cmd0, chan0, len0, err0}, {1'b1, 8'h03, 2'd2, 5'd8, 1'b0});
    handshake(0, "after_crc_drop");

    // Single-channel build: IDENTIFY is 7 bytes
    fq = '{8'hF1, 8'h00, 8'hBA, 8'h00, 8'h00, 8'hCC, 8'hDD};
    send_fq(1, 0, 1, 0);
    chk("v1_ident", {mv1, cmd1, chan1, len1, err1, for1},
        {1'b1, 8'h00, 1'b0, 5'd7, 2'b00});
    handshake(1, "v1_drop");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
